// File: rtl/tennis_rally_core.sv
// tennis_rally_core
// Tennis game engine on an N_LEDS-long LED court. Both raw player buttons are
// synchronised, debounced and edge-detected. The ball speeds up on each
// successful return, early swings are faults, and the first player to
// WIN_SCORE points ends the game.
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-low reset (0 = reset asserted)
//   left_trigger  raw left-player button (asynchronous, bouncy)
//   right_trigger raw right-player button (asynchronous, bouncy)
//   ball          one-hot ball position, bit N_LEDS-1 = left end, bit 0 = right end
//                 (all ones while a point is shown, all zeros once the game is over)
//   score_left    left player points
//   score_right   right player points
//   game_over     high once either score has reached WIN_SCORE
//   winner        0 = left won, 1 = right won; meaningful only while game_over=1
//   step_period   current clk cycles per ball step
//   state_dbg     current FSM state encoding, for observation only
//
// Button handshake: a press is a single-cycle pulse that the FSM consumes in
// the cycle it is high; there is no back-pressure, so a press arriving in a
// state that does not listen to that player is dropped.
module tennis_rally_core #(
   parameter int N_LEDS     = 16,
   parameter int DEB_CYCLES = 1000000,
   parameter int STEP_INIT  = 25000000,
   parameter int STEP_DEC   = 1000000,
   parameter int STEP_MIN   = 5000000,
   parameter int SCORE_W    = 4,
   parameter int WIN_SCORE  = 7
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               left_trigger,
   input  logic               right_trigger,
   output logic [N_LEDS-1:0]  ball,
   output logic [SCORE_W-1:0] score_left,
   output logic [SCORE_W-1:0] score_right,
   output logic               game_over,
   output logic               winner,
   output logic [31:0]        step_period,
   output logic [2:0]         state_dbg
);

   typedef enum logic [2:0] {
      S_SERVE_L = 3'd0,
      S_SERVE_R = 3'd1,
      S_MOVE_R  = 3'd2,
      S_MOVE_L  = 3'd3,
      S_POINT   = 3'd4,
      S_OVER    = 3'd5
   } state_t;

   localparam int                 DEB_W     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
   localparam logic [31:0]        P_INIT    = 32'(STEP_INIT);
   localparam logic [31:0]        P_DEC     = 32'(STEP_DEC);
   localparam logic [31:0]        P_MIN     = 32'(STEP_MIN);
   localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
   localparam logic [N_LEDS-1:0]  LEFT_END  = {1'b1, {(N_LEDS-1){1'b0}}};
   localparam logic [N_LEDS-1:0]  RIGHT_END = {{(N_LEDS-1){1'b0}}, 1'b1};
   // Index 1 = left player, index 0 = right player in the input pipeline.
   localparam int PL = 1;
   localparam int PR = 0;

   // ------------------------------------------------------------------
   // Input conditioning: 2-FF synchroniser, debounce, rising-edge pulse.
   // The debounced level flips on the DEB_CYCLES-th consecutive cycle in
   // which the synchronised input disagrees with it; any agreement restarts
   // the count, so bounces shorter than DEB_CYCLES never get through.
   // ------------------------------------------------------------------
   logic [1:0]       sync1, sync2, deb, deb_d, press;
   logic [DEB_W-1:0] deb_cnt [2];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1      <= '0;
         sync2      <= '0;
         deb        <= '0;
         deb_d      <= '0;
         press      <= '0;
         deb_cnt[0] <= '0;
         deb_cnt[1] <= '0;
      end else begin
         sync1 <= {left_trigger, right_trigger};
         sync2 <= sync1;
         deb_d <= deb;
         press <= deb & ~deb_d;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == deb[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               deb[i]     <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Rally FSM
   // ------------------------------------------------------------------
   state_t             state;
   logic [31:0]        timer;
   logic               last_left;   // 1 when the left player won the last point
   logic               tick;
   logic               at_left, at_right;
   logic               point_l, point_r, ret;
   logic [31:0]        step_next;
   logic [SCORE_W-1:0] new_left, new_right;

   assign state_dbg = state;
   assign tick      = (timer == step_period - 32'd1);
   assign at_left   = (ball == LEFT_END);
   assign at_right  = (ball == RIGHT_END);
   assign new_left  = (score_left  < WIN) ? score_left  + 1'b1 : score_left;
   assign new_right = (score_right < WIN) ? score_right + 1'b1 : score_right;

   // Each return shortens the step, never below STEP_MIN.
   assign step_next = (step_period >= P_MIN + P_DEC) ? step_period - P_DEC : P_MIN;

   // Only the player the ball is travelling toward is listened to; a press
   // before the ball reaches that player's end is an early-swing fault, and
   // a press on the same edge as the final tick still counts as a return.
   always_comb begin
      point_l = 1'b0;
      point_r = 1'b0;
      ret     = 1'b0;
      case (state)
         S_MOVE_R: begin
            if (press[PR]) begin
               if (at_right) ret = 1'b1;
               else          point_l = 1'b1;
            end else if (tick && at_right) begin
               point_l = 1'b1;
            end
         end
         S_MOVE_L: begin
            if (press[PL]) begin
               if (at_left) ret = 1'b1;
               else         point_r = 1'b1;
            end else if (tick && at_left) begin
               point_r = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_SERVE_L;
         ball        <= LEFT_END;
         score_left  <= '0;
         score_right <= '0;
         game_over   <= 1'b0;
         winner      <= 1'b0;
         step_period <= P_INIT;
         timer       <= '0;
         last_left   <= 1'b0;
      end else begin
         case (state)
            S_SERVE_L: begin
               ball  <= LEFT_END;
               timer <= '0;
               if (press[PL]) state <= S_MOVE_R;
            end
            S_SERVE_R: begin
               ball  <= RIGHT_END;
               timer <= '0;
               if (press[PR]) state <= S_MOVE_L;
            end
            S_MOVE_R, S_MOVE_L: begin
               if (point_l || point_r) begin
                  if (point_l) score_left  <= new_left;
                  if (point_r) score_right <= new_right;
                  if ((point_l && new_left == WIN) || (point_r && new_right == WIN)) begin
                     game_over <= 1'b1;
                     winner    <= point_r;
                  end
                  last_left   <= point_l;
                  ball        <= '1;
                  step_period <= P_INIT;
                  timer       <= '0;
                  state       <= S_POINT;
               end else if (ret) begin
                  step_period <= step_next;
                  timer       <= '0;
                  state       <= (state == S_MOVE_R) ? S_MOVE_L : S_MOVE_R;
               end else if (tick) begin
                  timer <= '0;
                  ball  <= (state == S_MOVE_R) ? (ball >> 1) : (ball << 1);
               end else begin
                  timer <= timer + 32'd1;
               end
            end
            S_POINT: begin
               // Blink marker held for one full STEP_INIT period.
               if (tick) begin
                  timer <= '0;
                  if (game_over) begin
                     ball  <= '0;
                     state <= S_OVER;
                  end else if (last_left) begin
                     ball  <= RIGHT_END;
                     state <= S_SERVE_R;
                  end else begin
                     ball  <= LEFT_END;
                     state <= S_SERVE_L;
                  end
               end else begin
                  timer <= timer + 32'd1;
               end
            end
            S_OVER: begin
               ball      <= '0;
               game_over <= 1'b1;
               timer     <= '0;
            end
            default: begin
               state <= S_SERVE_L;
               ball  <= LEFT_END;
               timer <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tennis_rally_core.sv
// Testbench for tennis_rally_core with a short debounce and fast steps.
// A monitor compares every change of the ball against an expected queue of
// {position, cycles since previous change}; the stimulus code pushes each
// expected leg of the rally before it triggers it.
module tb_tennis_rally_core;

   localparam int N       = 16;
   localparam int DEB     = 4;
   localparam int P_INIT  = 10;
   localparam int P_DEC   = 2;
   localparam int P_MIN   = 4;
   localparam int SW      = 4;
   localparam int WIN     = 7;
   localparam int LATENCY = DEB + 3;   // raw edge to FSM action, in edges

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          rst_n;
   logic          left_trigger, right_trigger;
   logic [N-1:0]  ball;
   logic [SW-1:0] score_left, score_right;
   logic          game_over, winner;
   logic [31:0]   step_period;
   logic [2:0]    state_dbg;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   tennis_rally_core #(
      .N_LEDS(N), .DEB_CYCLES(DEB), .STEP_INIT(P_INIT), .STEP_DEC(P_DEC),
      .STEP_MIN(P_MIN), .SCORE_W(SW), .WIN_SCORE(WIN)
   ) dut (
      .clk(clk), .reset(rst_n), .left_trigger(left_trigger), .right_trigger(right_trigger),
      .ball(ball), .score_left(score_left), .score_right(score_right),
      .game_over(game_over), .winner(winner), .step_period(step_period),
      .state_dbg(state_dbg)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errs   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [N-1:0] exp_q[$];
   int           gap_q[$];        // 0 = interval not checked
   bit           mon_en = 1'b0;
   bit           mon_primed = 1'b0;
   logic [N-1:0] prev_ball;
   int           last_chg;

   always @(negedge clk) begin
      if (mon_en) begin
         if (!mon_primed) begin
            prev_ball  = ball;
            last_chg   = cyc;
            mon_primed = 1'b1;
         end else if (ball !== prev_ball) begin
            if (exp_q.size() == 0) begin
               check("ball_unexpected", 32'(ball), 32'(prev_ball));
            end else begin
               logic [N-1:0] e;
               int           g;
               e = exp_q.pop_front();
               g = gap_q.pop_front();
               check("ball", 32'(ball), 32'(e));
               if (g != 0) check("step_gap", 32'(cyc - last_chg), 32'(g));
            end
            prev_ball = ball;
            last_chg  = cyc;
         end
      end
   end

   function automatic logic [N-1:0] onehot(input int b);
      logic [N-1:0] v;
      v    = '0;
      v[b] = 1'b1;
      return v;
   endfunction

   task automatic push_exp(input logic [N-1:0] v, input int gap);
      exp_q.push_back(v);
      gap_q.push_back(gap);
   endtask

   // Positions from from_b to to_b inclusive; first step after a serve or
   // return has an unconstrained interval.
   task automatic push_leg(input bit to_right, input int from_b, input int to_b, input int p);
      int  b;
      bit  first;
      b     = from_b;
      first = 1'b1;
      forever begin
         push_exp(onehot(b), first ? 0 : p);
         first = 1'b0;
         if (b == to_b) break;
         b = to_right ? b - 1 : b + 1;
      end
   endtask

   // ---------------- drivers ----------------
   int exp_p = P_INIT;

   task automatic set_trig(input bit left, input logic v);
      if (left) left_trigger = v;
      else      right_trigger = v;
   endtask

   task automatic press(input bit left, input int w);
      repeat (w) @(negedge clk);
      set_trig(left, 1'b1);
      repeat (DEB + 4) @(negedge clk);
      set_trig(left, 1'b0);
      repeat (DEB + 4) @(negedge clk);
   endtask

   task automatic press_bouncy(input bit left);
      set_trig(left, 1'b1); @(negedge clk);
      set_trig(left, 1'b0); @(negedge clk);
      set_trig(left, 1'b1); @(negedge clk);
      set_trig(left, 1'b0); @(negedge clk);
      press(left, 0);
   endtask

   task automatic wait_ball(input logic [N-1:0] v, input string tag);
      int k;
      k = 0;
      while (ball !== v && k < 400) begin
         @(negedge clk);
         k++;
      end
      check(tag, 32'(ball), 32'(v));
   endtask

   task automatic wait_drain(input string tag);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      check(tag, exp_q.size(), 0);
   endtask

   // Swing so the press lands mid-way through the step in which the ball
   // sits on tgt_bit: start from a position d steps upstream plus w cycles.
   task automatic swing(input bit left, input int tgt_bit);
      int d, w;
      d = 0;
      while (d * exp_p + exp_p / 2 < LATENCY) d++;
      w = d * exp_p + exp_p / 2 - LATENCY;
      wait_ball(onehot(left ? tgt_bit - d : tgt_bit + d), "swing_sync");
      press(left, w);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ball"}, 32'(ball), 32'h8000);
      check({tag, "_score_l"}, 32'(score_left), 0);
      check({tag, "_score_r"}, 32'(score_right), 0);
      check({tag, "_game_over"}, 32'(game_over), 0);
      check({tag, "_winner"}, 32'(winner), 0);
      check({tag, "_step"}, step_period, P_INIT);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n         = 1'b0;
      left_trigger  = 1'b0;
      right_trigger = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("in_reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_vals("after_reset");
      mon_en = 1'b1;
      @(negedge clk);

      // Rally: bouncy serve, returns speed up to the floor, then early swing.
      push_leg(1, 14, 0, 10);
      press_bouncy(1);
      push_leg(0, 1, 15, 8);
      swing(0, 0);
      exp_p = 8;
      check("step_after_ret1", step_period, 8);
      push_leg(1, 14, 0, 6);
      swing(1, 15);
      exp_p = 6;
      check("step_after_ret2", step_period, 6);
      push_leg(0, 1, 15, 4);
      swing(0, 0);
      exp_p = 4;
      check("step_after_ret3", step_period, 4);
      push_leg(1, 14, 2, 4);
      swing(1, 15);
      check("step_clamped", step_period, 4);
      push_exp('1, 0);
      push_exp(onehot(0), 10);
      swing(0, 2);
      exp_p = 10;
      wait_drain("early_swing");
      check("early_score_l", 32'(score_left), 1);
      check("early_score_r", 32'(score_right), 0);
      check("early_step_restored", step_period, 10);

      // Right serves, left misses: right scores, left serves next.
      push_leg(0, 1, 15, 10);
      push_exp('1, 10);
      push_exp(onehot(15), 10);
      press(0, 0);
      wait_drain("left_miss");
      check("miss_score_r", 32'(score_right), 1);

      // Left serves, right misses.
      push_leg(1, 14, 0, 10);
      push_exp('1, 10);
      push_exp(onehot(0), 10);
      press(1, 0);
      wait_drain("right_miss");
      check("miss_score_l", 32'(score_left), 2);

      // Right serves, left returns, right misses, until left reaches WIN.
      for (int k = 3; k <= WIN; k++) begin
         push_leg(0, 1, 15, 10);
         push_leg(1, 14, 0, 8);
         push_exp('1, 8);
         push_exp((k == WIN) ? '0 : onehot(0), 10);
         exp_p = 10;
         press(0, 0);
         swing(1, 15);
         wait_drain("game_rally");
         check("game_score_l", 32'(score_left), 32'(k));
      end
      check("over_flag", 32'(game_over), 1);
      check("over_winner", 32'(winner), 0);
      check("over_ball", 32'(ball), 0);
      check("over_score_r", 32'(score_right), 1);

      // Presses in OVER change nothing (the monitor flags any ball change).
      press(1, 0);
      press(0, 0);
      left_trigger  = 1'b1;
      right_trigger = 1'b1;
      repeat (DEB + 6) @(negedge clk);
      left_trigger  = 1'b0;
      right_trigger = 1'b0;
      repeat (DEB + 6) @(negedge clk);
      check("over_hold_score_l", 32'(score_left), 7);
      check("over_hold_flag", 32'(game_over), 1);
      check("over_hold_ball", 32'(ball), 0);

      // Reset out of OVER, then reset again in the middle of MOVE_L.
      push_exp(onehot(15), 0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      wait_drain("reset_from_over");
      check_reset_vals("post_over_reset");

      exp_p = 10;
      push_leg(1, 14, 0, 10);
      press(1, 0);
      push_leg(0, 1, 4, 8);
      swing(0, 0);
      wait_ball(onehot(4), "mid_move_l");
      push_exp(onehot(15), 0);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_vals("async_reset");
      check("async_reset_state", 32'(state_dbg), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      wait_drain("final");
      check_reset_vals("final");

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
